exe_mem_pipe_reg: RTL and testbench

- EXE→MEM pipeline register. It is the producer side of the GPR bypass interface.
- Drives the EXE-level bypass signals combinationally from the instruction now in EXE, and registers that instruction into the MEM stage.
- Sequences multi-cycle EXE ops (MUL/DIV) with a countdown FSM and holds upstream stages while the op is busy.
- Applies pipeline stall and flush with fixed priority.

---
 rtl/exe_mem_pipe_reg_pkg.sv | 15 +
 rtl/exe_mem_pipe_reg_mc.sv | 73 +++++++
 rtl/exe_mem_pipe_reg.sv | 120 ++++++++++++
 tb/tb_exe_mem_pipe_reg.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_mem_pipe_reg_pkg.sv
// Shared types and constants for the EXE->MEM pipeline register.
// Holds the multi-cycle FSM encoding and GPR geometry.
package exe_mem_pipe_reg_pkg;

    localparam int GPR_ADDR_W = 5;
    localparam int GPR_DATA_W = 32;
    localparam logic [GPR_ADDR_W-1:0] GPR_ZERO = 5'd0;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/exe_mem_pipe_reg_mc.sv
// Multi-cycle op sequencer: countdown FSM plus result capture.
// Busy covers the entry cycle and every BUSY cycle, MC_LATENCY in total.
module exe_mem_pipe_reg_mc
    import exe_mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W     = GPR_DATA_W,
    parameter int MC_LATENCY = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic [DATA_W-1:0] i_result,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result
);

    localparam int CW = $clog2(MC_LATENCY);

    mc_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] res_q, res_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            MC_IDLE: begin
                if (i_start) begin
                    state_d = MC_BUSY;
                    cnt_d   = CW'(MC_LATENCY - 1);
                end
            end
            MC_BUSY: begin
                // The entry cycle already counted, so capture when we hit zero.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = MC_DONE;
                    res_d   = i_result;
                end
            end
            MC_DONE: begin
                if (!i_stall) state_d = MC_IDLE;
            end
            default: state_d = MC_IDLE;
        endcase
        if (i_flush) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign o_busy   = i_rst_n & ((state_q == MC_BUSY) |
                      ((state_q == MC_IDLE) & i_start & ~i_flush));
    assign o_done   = (state_q == MC_DONE);
    assign o_result = res_q;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register and producer side of the GPR bypass.
// MEM update priority: flush, stall, multi-cycle bubble, normal load.
module exe_mem_pipe_reg
    import exe_mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W     = GPR_DATA_W,
    parameter int ADDR_W     = GPR_ADDR_W,
    parameter int MC_LATENCY = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_EXE_valid,
    input  logic              i_EXE_we,
    input  logic [ADDR_W-1:0] i_EXE_waddr,
    input  logic [DATA_W-1:0] i_EXE_wdata,
    input  logic              i_EXE_is_load,
    input  logic              i_EXE_is_multicycle,
    input  logic [DATA_W-1:0] i_EXE_mc_result,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_EXE_busy,
    output logic              o_BP_EXE_we,
    output logic [ADDR_W-1:0] o_BP_EXE_waddr,
    output logic [DATA_W-1:0] o_BP_EXE_wdata,
    output logic              o_BP_EXE_get_result_in_EXE,
    output logic              o_BP_EXE_get_result_in_MEM,
    output logic              o_MEM_valid,
    output logic              o_MEM_we,
    output logic [ADDR_W-1:0] o_MEM_waddr,
    output logic [DATA_W-1:0] o_MEM_wdata,
    output logic              o_MEM_get_result_in_MEM
);

    logic              we_eff;
    logic              mc_busy;
    logic              mc_done;
    logic [DATA_W-1:0] mc_res;

    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ld_q, ld_d;

    exe_mem_pipe_reg_mc #(
        .DATA_W     (DATA_W),
        .MC_LATENCY (MC_LATENCY)
    ) u_mc (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_EXE_valid & i_EXE_is_multicycle),
        .i_flush  (i_flush),
        .i_stall  (i_stall),
        .i_result (i_EXE_mc_result),
        .o_busy   (mc_busy),
        .o_done   (mc_done),
        .o_result (mc_res)
    );

    assign we_eff = i_EXE_valid & i_EXE_we &
                    (i_EXE_waddr != ADDR_W'(GPR_ZERO));

    assign o_EXE_busy     = mc_busy;
    assign o_BP_EXE_we    = we_eff;
    assign o_BP_EXE_waddr = i_EXE_waddr;
    assign o_BP_EXE_wdata = mc_done ? mc_res : i_EXE_wdata;
    assign o_BP_EXE_get_result_in_MEM =
        we_eff & (i_EXE_is_load | (i_EXE_is_multicycle & ~mc_done));
    assign o_BP_EXE_get_result_in_EXE = ~o_BP_EXE_get_result_in_MEM;

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        if (i_flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            waddr_d = '0;
            wdata_d = '0;
            ld_d    = 1'b0;
        end else if (i_stall) begin
            valid_d = valid_q;
        end else if (mc_busy) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            ld_d    = 1'b0;
        end else begin
            valid_d = i_EXE_valid;
            we_d    = we_eff;
            waddr_d = i_EXE_waddr;
            wdata_d = o_BP_EXE_wdata;
            ld_d    = i_EXE_valid & i_EXE_is_load;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ld_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
        end
    end

    assign o_MEM_valid             = valid_q;
    assign o_MEM_we                = we_q;
    assign o_MEM_waddr             = waddr_q;
    assign o_MEM_wdata             = wdata_q;
    assign o_MEM_get_result_in_MEM = ld_q;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed plus random bench for exe_mem_pipe_reg with MC_LATENCY=4.
// Expected values come from a remaining-cycles model of the op lifecycle.
module tb_exe_mem_pipe_reg;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, we = 1'b0, is_load = 1'b0, is_mc = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0, mc_result = '0;
    logic        stall = 1'b0, flush = 1'b0;

    logic        busy, bp_we, bp_exe, bp_mem;
    logic [4:0]  bp_waddr, mem_waddr;
    logic [31:0] bp_wdata, mem_wdata;
    logic        mem_valid, mem_we, mem_ld;

    int checks = 0;
    int errors = 0;

    // model: op lifecycle in terms of busy cycles left / result parked
    int          m_left;
    bit          m_done;
    logic [31:0] m_res;
    logic        e_valid, e_we, e_ld;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    exe_mem_pipe_reg #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .MC_LATENCY (L)
    ) dut (
        .i_clk                      (clk),
        .i_rst_n                    (rst_n),
        .i_EXE_valid                (valid),
        .i_EXE_we                   (we),
        .i_EXE_waddr                (waddr),
        .i_EXE_wdata                (wdata),
        .i_EXE_is_load              (is_load),
        .i_EXE_is_multicycle        (is_mc),
        .i_EXE_mc_result            (mc_result),
        .i_stall                    (stall),
        .i_flush                    (flush),
        .o_EXE_busy                 (busy),
        .o_BP_EXE_we                (bp_we),
        .o_BP_EXE_waddr             (bp_waddr),
        .o_BP_EXE_wdata             (bp_wdata),
        .o_BP_EXE_get_result_in_EXE (bp_exe),
        .o_BP_EXE_get_result_in_MEM (bp_mem),
        .o_MEM_valid                (mem_valid),
        .o_MEM_we                   (mem_we),
        .o_MEM_waddr                (mem_waddr),
        .o_MEM_wdata                (mem_wdata),
        .o_MEM_get_result_in_MEM    (mem_ld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit f_we_eff();
        return valid && we && (waddr != 5'd0);
    endfunction

    function automatic bit f_idle();
        return (m_left == 0) && !m_done;
    endfunction

    function automatic bit f_busy();
        return (m_left > 0) || (f_idle() && valid && is_mc && !flush);
    endfunction

    task automatic model_reset();
        m_left = 0; m_done = 0; m_res = '0;
        e_valid = 0; e_we = 0; e_ld = 0; e_waddr = '0; e_wdata = '0;
    endtask

    task automatic model_edge();
        bit b;
        bit gm;
        b = f_busy();
        gm = 0;
        if (flush) begin
            e_valid = 0; e_we = 0; e_ld = 0; e_waddr = '0; e_wdata = '0;
        end else if (stall) begin
            gm = 0;
        end else if (b) begin
            e_valid = 0; e_we = 0; e_ld = 0;
        end else begin
            e_valid = valid;
            e_we    = f_we_eff();
            e_waddr = waddr;
            e_wdata = m_done ? m_res : wdata;
            e_ld    = valid && is_load;
        end
        if (flush) begin
            m_left = 0; m_done = 0;
        end else if (m_left > 0) begin
            if (m_left == 1) begin
                m_done = 1;
                m_res  = mc_result;
            end
            m_left--;
        end else if (m_done) begin
            if (!stall) m_done = 0;
        end else if (valid && is_mc) begin
            m_left = L - 1;
        end
    endtask

    task automatic check_comb();
        bit gm;
        if (valid && is_load && is_mc) begin
            $display("FAIL illegal_op load and multicycle together");
            $fatal(1, "illegal stimulus");
        end
        gm = f_we_eff() && (is_load || (is_mc && !m_done));
        chk("busy", busy, f_busy());
        chk("bp_we", bp_we, f_we_eff());
        chk("bp_waddr", bp_waddr, waddr);
        chk("bp_wdata", bp_wdata, m_done ? m_res : wdata);
        chk("bp_in_mem", bp_mem, gm);
        chk("bp_in_exe", bp_exe, !gm);
    endtask

    task automatic check_mem();
        chk("mem_valid", mem_valid, e_valid);
        chk("mem_we", mem_we, e_we);
        chk("mem_ld", mem_ld, e_ld);
        if (e_valid) begin
            chk("mem_waddr", mem_waddr, e_waddr);
            chk("mem_wdata", mem_wdata, e_wdata);
        end
    endtask

    task automatic step();
        #1 check_comb();
        @(posedge clk);
        model_edge();
        #1 check_mem();
        @(negedge clk);
    endtask

    task automatic op(input bit v, input bit w, input logic [4:0] a,
                      input logic [31:0] d, input bit ld, input bit mc);
        valid = v; we = w; waddr = a; wdata = d; is_load = ld; is_mc = mc;
    endtask

    task automatic check_mem_zero(input string tag);
        chk({tag, "_valid"}, mem_valid, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_waddr"}, mem_waddr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_ld"}, mem_ld, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int nb;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_mem_zero("reset");
        rst_n = 1'b1;

        // single-cycle ALU op
        op(1, 1, 5'd5, 32'h1234, 0, 0);
        #1 chk("alu_exe", bp_exe, 1);
        chk("alu_bpdata", bp_wdata, 32'h1234);
        step();
        chk("alu_mvalid", mem_valid, 1);
        chk("alu_mwe", mem_we, 1);
        chk("alu_maddr", mem_waddr, 5);
        chk("alu_mdata", mem_wdata, 32'h1234);
        chk("alu_mld", mem_ld, 0);

        // loads, to r7 and to r0
        op(1, 1, 5'd7, 32'h0, 1, 0);
        #1 chk("ld_inmem", bp_mem, 1);
        chk("ld_inexe", bp_exe, 0);
        step();
        chk("ld_mld", mem_ld, 1);
        op(1, 1, 5'd0, 32'h0, 1, 0);
        #1 chk("ld0_inmem", bp_mem, 0);
        step();
        chk("ld0_mwe", mem_we, 0);

        // multi-cycle op to r9
        op(1, 1, 5'd9, 32'h0BAD0BAD, 0, 1);
        nb = 0;
        for (int k = 0; k < L; k++) begin
            mc_result = (k == L - 1) ? 32'hDEADBEEF : $urandom;
            #1 if (busy) nb++;
            step();
            chk("mc_bubble", mem_valid, 0);
        end
        chk("mc_busy_cycles", nb, L);
        #1 chk("mc_done_busy", busy, 0);
        chk("mc_done_exe", bp_exe, 1);
        chk("mc_done_bp", bp_wdata, 32'hDEADBEEF);
        mc_result = 32'h0;
        step();
        chk("mc_mdata", mem_wdata, 32'hDEADBEEF);
        chk("mc_maddr", mem_waddr, 9);
        chk("mc_mvalid", mem_valid, 1);
        op(0, 0, 5'd0, 32'h0, 0, 0);
        step();

        // flush on second BUSY cycle
        op(1, 1, 5'd9, 32'h0, 0, 1);
        mc_result = 32'h55555555;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        op(0, 0, 5'd0, 32'h0, 0, 0);
        #1 chk("fl_busy", busy, 0);
        chk("fl_mvalid", mem_valid, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fl_no_r9", mem_valid && mem_waddr == 5'd9, 0);
        end

        // stall with flush, then stall in DONE
        op(1, 1, 5'd3, 32'h33, 0, 0);
        step();
        chk("sf_pre", mem_valid, 1);
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        chk("sf_valid", mem_valid, 0);
        op(1, 1, 5'd12, 32'h0, 0, 1);
        for (int k = 0; k < L; k++) begin
            mc_result = (k == L - 1) ? 32'hCAFE0001 : $urandom;
            step();
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("st_hold", mem_valid, 0);
        end
        stall = 1'b0;
        step();
        chk("st_valid", mem_valid, 1);
        chk("st_addr", mem_waddr, 12);
        chk("st_data", mem_wdata, 32'hCAFE0001);

        // async reset while BUSY
        op(1, 1, 5'd9, 32'h0, 0, 1);
        step();
        step();
        #2 rst_n = 1'b0;
        #1 check_mem_zero("arst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        op(0, 0, 5'd0, 32'h0, 0, 0);
        rst_n = 1'b1;
        step();
        op(1, 1, 5'd4, 32'hABCD, 0, 0);
        step();
        chk("post_valid", mem_valid, 1);
        chk("post_addr", mem_waddr, 4);
        chk("post_data", mem_wdata, 32'hABCD);

        // random traffic; upstream holds the op while it occupies EXE
        for (int n = 0; n < 400; n++) begin
            int kind;
            flush = ($urandom_range(15) == 0);
            stall = ($urandom_range(4) == 0);
            mc_result = $urandom;
            if (!(m_left > 0 || m_done)) begin
                kind = $urandom_range(3);
                op($urandom_range(3) != 0, $urandom_range(3) != 0,
                   ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom),
                   $urandom, kind == 0, kind == 1);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
